// File: rtl/ccal_frame_seq.sv
// Frame sequencer in front of the CCAL labeller: thresholds and gates the raw
// pixel stream, polices line gap / width / height limits and counts CCAL records.
`timescale 1ns/1ps
module ccal_frame_seq #(
    parameter int PW      = 8,
    parameter int Wb      = 11,
    parameter int Hb      = 10,
    parameter int Nb      = 10,
    parameter int GAP_MIN = 8,
    parameter int CLR_CYC = 4,
    parameter int FLUSH   = (1 << Wb) + 16
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          Run,
    input  logic [Hb-1:0] FrameH,
    input  logic [PW-1:0] Thr,
    input  logic          InFS,
    input  logic          InLV,
    input  logic [PW-1:0] InPix,
    output logic          CcSrst,
    output logic          CcDataEn,
    output logic          CcPixel,
    input  logic          CcOEn,
    output logic          Busy,
    output logic          FrameDone,
    output logic [Nb-1:0] ObjCnt,
    output logic          LineErr,
    output logic          WidthErr,
    output logic          OvfErr
);

    localparam int TMAX = (FLUSH > GAP_MIN) ? ((FLUSH > CLR_CYC) ? FLUSH : CLR_CYC)
                                            : ((GAP_MIN > CLR_CYC) ? GAP_MIN : CLR_CYC);
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_MIN - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH - 1);
    localparam logic [Wb-1:0] MAX_PIX    = {Wb{1'b1}};
    localparam logic [Nb-1:0] MAX_RES    = {Nb{1'b1}};

    typedef enum logic [6:0] {
        S_IDLE  = 7'b0000001,
        S_CLEAR = 7'b0000010,
        S_WAITF = 7'b0000100,
        S_LINE  = 7'b0001000,
        S_GAP   = 7'b0010000,
        S_FLUSH = 7'b0100000,
        S_DONE  = 7'b1000000
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [Wb-1:0] pix_cnt_q, pix_cnt_d;
    logic [Hb-1:0] line_cnt_q, line_cnt_d;
    logic [Hb-1:0] frame_h_q, frame_h_d;
    logic [PW-1:0] thr_q, thr_d;
    logic [Nb-1:0] res_cnt_q, res_cnt_d;
    logic [Nb-1:0] obj_cnt_q, obj_cnt_d;
    logic          lv_q;
    logic          line_act_q, line_act_d;
    logic          en_q, en_d;
    logic          pix_q, pix_d;
    logic          line_err_q, line_err_d;
    logic          width_err_q, width_err_d;
    logic          ovf_err_q, ovf_err_d;

    always_comb begin
        // NOTE: every signal driven here gets its default first, so no path can infer a latch.
        state_d     = state_q;
        tmr_d       = tmr_q;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        frame_h_d   = frame_h_q;
        thr_d       = thr_q;
        res_cnt_d   = res_cnt_q;
        obj_cnt_d   = obj_cnt_q;
        line_act_d  = line_act_q;
        en_d        = 1'b0;
        pix_d       = 1'b0;
        line_err_d  = line_err_q;
        width_err_d = width_err_q;
        ovf_err_d   = ovf_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_CLEAR;
                    tmr_d   = '0;
                end
            end
            S_CLEAR: begin
                line_cnt_d = '0;
                res_cnt_d  = '0;
                pix_cnt_d  = '0;
                line_act_d = 1'b0;
                if (tmr_q == CLR_LAST) state_d = S_WAITF;
                else                   tmr_d   = tmr_q + 1'b1;
            end
            S_WAITF: begin
                if (!Run) begin
                    state_d = S_IDLE;
                end else if (InFS) begin
                    frame_h_d  = (FrameH == '0) ? Hb'(1) : FrameH;
                    thr_d      = Thr;
                    line_cnt_d = '0;
                    line_act_d = 1'b0;
                    state_d    = S_LINE;
                end
            end
            S_LINE: begin
                // A line is only accepted from a rising edge seen here; one already
                // high on entry (started with InFS) is ignored until it falls.
                if (InLV && !lv_q) begin
                    line_act_d = 1'b1;
                    pix_cnt_d  = Wb'(1);
                    en_d       = 1'b1;
                end else if (InLV && line_act_q) begin
                    if (pix_cnt_q == MAX_PIX) begin
                        width_err_d = 1'b1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        en_d      = 1'b1;
                    end
                end else if (!InLV && line_act_q) begin
                    line_act_d = 1'b0;
                    line_cnt_d = line_cnt_q + 1'b1;
                    tmr_d      = CW'(1);
                    state_d    = S_GAP;
                end
                pix_d = en_d & (InPix >= thr_q);
            end
            S_GAP: begin
                // tmr counts consecutive idle cycles; a line rising here is dropped.
                if (InLV) begin
                    tmr_d      = '0;
                    line_err_d = 1'b1;
                end else if (tmr_q == GAP_LAST) begin
                    tmr_d   = '0;
                    state_d = (line_cnt_q == frame_h_q) ? S_FLUSH : S_LINE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (tmr_q == FLUSH_LAST) state_d = S_DONE;
                else                     tmr_d   = tmr_q + 1'b1;
            end
            S_DONE: begin
                obj_cnt_d = res_cnt_q;
                tmr_d     = '0;
                state_d   = Run ? S_CLEAR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // OvfErr marks a record that could not be counted.
        if (CcOEn && !(state_q inside {S_IDLE, S_CLEAR})) begin
            if (res_cnt_q == MAX_RES) ovf_err_d = 1'b1;
            else                      res_cnt_d = res_cnt_q + 1'b1;
        end

        if (state_d == S_CLEAR && state_q != S_CLEAR) begin
            line_err_d  = 1'b0;
            width_err_d = 1'b0;
            ovf_err_d   = 1'b0;
        end
    end

    // NOTE: all registers, including latched frame parameters, take a known value on nRST.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            frame_h_q   <= '0;
            thr_q       <= '0;
            res_cnt_q   <= '0;
            obj_cnt_q   <= '0;
            lv_q        <= 1'b0;
            line_act_q  <= 1'b0;
            en_q        <= 1'b0;
            pix_q       <= 1'b0;
            line_err_q  <= 1'b0;
            width_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            frame_h_q   <= frame_h_d;
            thr_q       <= thr_d;
            res_cnt_q   <= res_cnt_d;
            obj_cnt_q   <= obj_cnt_d;
            lv_q        <= InLV;
            line_act_q  <= line_act_d;
            en_q        <= en_d;
            pix_q       <= pix_d;
            line_err_q  <= line_err_d;
            width_err_q <= width_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    // CcSrst decodes straight from state so an async reset reaches CCAL immediately.
    assign CcSrst    = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign Busy      = (state_q != S_IDLE);
    assign FrameDone = (state_q == S_DONE);
    assign CcDataEn  = en_q;
    assign CcPixel   = pix_q;
    assign ObjCnt    = obj_cnt_q;
    assign LineErr   = line_err_q;
    assign WidthErr  = width_err_q;
    assign OvfErr    = ovf_err_q;

endmodule
